memoria_datos_param: RTL and testbench

//  Parametrised byte-addressed MIPS data memory, little-endian; byte k of a word at address A+k.

---
 rtl/memoria_datos_param.sv | 198 +++++++++++++++++++
 tb/tb_memoria_datos_param.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_datos_param.sv
// Byte-addressed little-endian data memory with sized/extended loads, alignment faults,
// a protected low region, a sequential clear engine and a registered debug read port.
module memoria_datos_param #(
    parameter int unsigned NUM_BITS   = 32,
    parameter int unsigned NUM_SLOTS  = 128,
    parameter int unsigned NUM_DIREC  = $clog2(NUM_SLOTS),
    parameter int unsigned PROT_BYTES = 4,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_write_enable,
    input  logic [1:0]           i_size,
    input  logic                 i_unsigned,
    input  logic [NUM_DIREC-1:0] i_direcc,
    input  logic [NUM_BITS-1:0]  i_data,
    output logic                 o_rsp_valid,
    output logic [NUM_BITS-1:0]  o_data,
    output logic                 o_misaligned,
    output logic                 o_busy,
    input  logic [NUM_DIREC-1:0] i_direcc_debug,
    output logic [NUM_BITS-1:0]  o_data_debug
);

    localparam int unsigned NumBytes = NUM_BITS / 8;
    localparam int unsigned NumWords = NUM_SLOTS / NumBytes;
    localparam int unsigned MaxAcc   = (NumBytes < 4) ? NumBytes : 4;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e               state_q, state_d;
    logic [NUM_DIREC-1:0] clr_idx_q, clr_idx_d;
    logic [NUM_DIREC-1:0] clr_base;

    logic [7:0]           mem_q [NUM_SLOTS];
    logic [7:0]           mem_d [NUM_SLOTS];

    logic                 accept;
    logic                 fault;
    logic                 prot;
    logic                 do_store;
    logic                 do_load;
    logic [2:0]           acc_bytes;
    logic [NUM_DIREC-1:0] byte_idx [4];
    logic [31:0]          raw;
    logic                 sign;
    logic [NUM_BITS-1:0]  load_val;

    logic [READ_LAT-1:0]  pv_q;
    logic [READ_LAT-1:0]  pm_q;
    logic [NUM_BITS-1:0]  pd_q [READ_LAT];

    logic [NUM_DIREC-1:0] dbg_base;
    logic [NUM_BITS-1:0]  dbg_word;
    logic [NUM_BITS-1:0]  dbg_q;

    // Clear engine
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            StClear: begin
                if (clr_idx_q == NUM_DIREC'(NumWords - 1)) begin
                    state_d   = StIdle;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            StIdle:  state_d = StIdle;
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign o_busy      = (state_q == StClear);
    assign o_req_ready = (state_q == StIdle);
    assign accept      = i_req_valid && o_req_ready && !i_reset;
    assign clr_base    = clr_idx_q * NUM_DIREC'(NumBytes);

    // Access size and alignment decode
    always_comb begin
        acc_bytes = 3'd1;
        fault     = 1'b0;
        unique case (i_size)
            2'b00: acc_bytes = 3'd1;
            2'b01: begin
                acc_bytes = 3'd2;
                fault     = i_direcc[0];
            end
            2'b10: begin
                acc_bytes = 3'd4;
                fault     = |i_direcc[1:0];
            end
            default: fault = 1'b1;
        endcase
    end

    assign prot     = 32'(i_direcc) < PROT_BYTES;
    assign do_store = accept && i_write_enable && !fault && !prot;
    assign do_load  = accept && !i_write_enable && !fault;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_idx[k]    = i_direcc + NUM_DIREC'(k);
            raw[8*k +: 8]  = mem_q[byte_idx[k]];
        end
    end

    always_comb begin
        sign = 1'b0;
        unique case (i_size)
            2'b00:   sign = raw[7] & ~i_unsigned;
            2'b01:   sign = raw[15] & ~i_unsigned;
            default: sign = raw[31];
        endcase
        load_val = '0;
        for (int i = 0; i < int'(NUM_BITS); i++) begin
            load_val[i] = (i < 8 * int'(acc_bytes)) ? raw[i % 32] : sign;
        end
    end

    // Clearing and stores never coincide: requests are only taken in StIdle
    always_comb begin
        mem_d = mem_q;
        if (state_q == StClear && !i_reset) begin
            for (int k = 0; k < int'(NumBytes); k++) begin
                mem_d[clr_base + NUM_DIREC'(k)] = 8'h00;
            end
        end else if (do_store) begin
            for (int k = 0; k < int'(MaxAcc); k++) begin
                if (k < int'(acc_bytes)) begin
                    mem_d[byte_idx[k]] = i_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Response pipeline; data/fault slots are zero unless they carry a response
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pv_q <= '0;
            pm_q <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= accept;
            pm_q[0] <= accept && fault;
            pd_q[0] <= do_load ? load_val : '0;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                pv_q[i] <= pv_q[i-1];
                pm_q[i] <= pm_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign o_rsp_valid  = pv_q[READ_LAT-1];
    assign o_misaligned = pm_q[READ_LAT-1];
    assign o_data       = pd_q[READ_LAT-1];

    // Debug reads the post-edge memory image so it shows writes made at the same edge
    assign dbg_base = (i_direcc_debug / NUM_DIREC'(NumBytes)) * NUM_DIREC'(NumBytes);

    always_comb begin
        dbg_word = '0;
        for (int k = 0; k < int'(NumBytes); k++) begin
            dbg_word[8*k +: 8] = mem_d[dbg_base + NUM_DIREC'(k)];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_word;
        end
    end

    assign o_data_debug = dbg_q;

endmodule

// File: tb/tb_memoria_datos_param.sv
// Bench for memoria_datos_param: byte-level memory model with a response queue, per-cycle
// comparison of all outputs, plus hand-computed literal expectations for directed vectors.
module tb_memoria_datos_param;

    localparam int LAT = 3;
    localparam int NS  = 128;
    localparam int NW  = NS / 4;
    localparam int AW  = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          rsp_valid;
    logic [31:0]   rdata;
    logic          rsp_mis;
    logic          busy;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_data;

    always #5 clk = ~clk;

    memoria_datos_param #(
        .NUM_BITS  (32),
        .NUM_SLOTS (NS),
        .NUM_DIREC (AW),
        .PROT_BYTES(4),
        .READ_LAT  (LAT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_write_enable(we),
        .i_size        (size),
        .i_unsigned    (uns),
        .i_direcc      (addr),
        .i_data        (wdata),
        .o_rsp_valid   (rsp_valid),
        .o_data        (rdata),
        .o_misaligned  (rsp_mis),
        .o_busy        (busy),
        .i_direcc_debug(dbg_addr),
        .o_data_debug  (dbg_data)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        mis;
    } rsp_t;

    logic [7:0]  mm [NS];
    rsp_t        rq [$];
    int          ecnt = 0;
    int          clr_cnt = 0;
    bit          started = 0;
    bit          mem_known = 0;
    logic [31:0] dbg_exp = 0;

    bit          lit_en = 0;
    logic [31:0] lit_data;
    logic        lit_mis;
    string       lit_name;

    function automatic logic [31:0] model_load(input int a, input int s, input bit u);
        longint v = 0;
        for (int k = 0; k < s; k++) v += longint'(mm[a+k]) << (8 * k);
        if ((!u || s == 4) && v >= (64'd1 << (8 * s - 1))) v -= (64'd1 << (8 * s));
        return v[31:0];
    endfunction

    function automatic logic [31:0] mword(input int a);
        int b = (a / 4) * 4;
        return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    endfunction

    initial begin : model
        int          s;
        bit          f;
        logic [31:0] d;
        forever begin
            @(posedge clk);
            ecnt++;
            if (rst) begin
                rq.delete();
                clr_cnt = NW;
                dbg_exp = 0;
                started = 1;
            end else if (started) begin
                if (clr_cnt > 0) begin
                    for (int k = 0; k < 4; k++) mm[(NW - clr_cnt) * 4 + k] = 8'h00;
                    clr_cnt--;
                    if (clr_cnt == 0) mem_known = 1;
                end else if (req_valid) begin
                    s = 1 << size;
                    f = (size == 2'b11) || (int'(addr) % s != 0);
                    d = 0;
                    if (!f) begin
                        if (we) begin
                            if (int'(addr) >= 4)
                                for (int k = 0; k < s; k++) mm[int'(addr) + k] = wdata[8*k +: 8];
                        end else begin
                            d = model_load(int'(addr), s, uns);
                        end
                    end
                    if (lit_en) begin
                        checks++;
                        if (d !== lit_data || f !== lit_mis) begin
                            errors++;
                            $display("FAIL model-%s: model data=%h mis=%b, required data=%h mis=%b",
                                     lit_name, d, f, lit_data, lit_mis);
                        end
                    end
                    rq.push_back('{due: ecnt + LAT - 1, data: d, mis: f});
                end
                dbg_exp = mword(int'(dbg_addr));
            end
        end
    end

    initial begin : compare
        rsp_t e;
        bit   ev;
        forever begin
            @(negedge clk);
            if (started) begin
                checks++;
                if (busy !== (clr_cnt > 0) || req_ready !== (clr_cnt == 0)) begin
                    errors++;
                    $display("FAIL busy/ready @%0d: got busy=%b ready=%b, required busy=%b",
                             ecnt, busy, req_ready, clr_cnt > 0);
                end
                if (rq.size() > 0 && rq[0].due == ecnt) begin
                    e  = rq.pop_front();
                    ev = 1;
                end else begin
                    e  = '{due: 0, data: 0, mis: 0};
                    ev = 0;
                end
                checks++;
                if (rsp_valid !== ev || rdata !== e.data || rsp_mis !== e.mis) begin
                    errors++;
                    $display("FAIL rsp @%0d: got v=%b d=%h m=%b, required v=%b d=%h m=%b",
                             ecnt, rsp_valid, rdata, rsp_mis, ev, e.data, e.mis);
                end
                if (mem_known) begin
                    checks++;
                    if (dbg_data !== dbg_exp) begin
                        errors++;
                        $display("FAIL debug @%0d: got %h, required %h", ecnt, dbg_data, dbg_exp);
                    end
                end
            end
        end
    end

    // Called at a negedge; holds the request across exactly one posedge
    task automatic req(input bit w, input logic [1:0] sz, input bit u, input int a,
                       input logic [31:0] d, input logic [31:0] ld, input logic lm,
                       input string nm);
        we = w; size = sz; uns = u; addr = a[AW-1:0]; wdata = d; req_valid = 1'b1;
        lit_en = 1; lit_data = ld; lit_mis = lm; lit_name = nm;
        @(negedge clk);
        req_valid = 1'b0;
        lit_en = 0;
    endtask

    task automatic ld(input logic [1:0] sz, input bit u, input int a, input logic [31:0] x,
                      input string nm);
        req(1'b0, sz, u, a, 32'h0, x, 1'b0, nm);
    endtask

    task automatic st(input logic [1:0] sz, input int a, input logic [31:0] d, input string nm);
        req(1'b1, sz, 1'b0, a, d, 32'h0, 1'b0, nm);
    endtask

    task automatic drain();
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic check_lit(input logic [31:0] got, input logic [31:0] want, input string nm);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    // Reset, then count busy cycles; optionally hammer a store while clearing
    task automatic reset_count(input bit hammer, input string nm);
        int n = 0;
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        if (hammer) begin
            we = 1'b1; size = 2'b10; addr = 7'h08; wdata = 32'hCAFEF00D; req_valid = 1'b1;
        end
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (n != NW) begin
            errors++;
            $display("FAIL %s: busy cycles %0d, required %0d", nm, n, NW);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1; req_valid = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = '0; wdata = '0; dbg_addr = '0;

        // 1: clear engine length and all-zero memory
        reset_count(1'b0, "clear-len-1");
        for (int i = 0; i < NW; i++) begin
            dbg_addr = AW'(i * 4 + (i % 4));
            @(negedge clk);
            check_lit(dbg_data, 32'h0, "dbg-zero");
        end

        // 2: word store, then sized/extended loads (first load is read-after-write)
        st(2'b10, 'h10, 32'h8899AABB, "sw10");
        ld(2'b10, 1'b0, 'h10, 32'h8899AABB, "lw10");
        ld(2'b00, 1'b0, 'h10, 32'hFFFFFFBB, "lb10");
        ld(2'b00, 1'b1, 'h13, 32'h00000088, "lbu13");
        ld(2'b01, 1'b0, 'h12, 32'hFFFF8899, "lh12");
        ld(2'b01, 1'b1, 'h10, 32'h0000AABB, "lhu10");
        ld(2'b00, 1'b0, 'h11, 32'hFFFFFFAA, "lb11");
        ld(2'b10, 1'b1, 'h10, 32'h8899AABB, "lwu10");

        // 3: partial stores use only the low bytes
        st(2'b01, 'h10, 32'hFFFF1234, "sh10");
        ld(2'b10, 1'b0, 'h10, 32'h88991234, "lw-after-sh");
        st(2'b00, 'h11, 32'hAAAAAA7F, "sb11");
        ld(2'b10, 1'b0, 'h10, 32'h88997F34, "lw-after-sb");

        // 4: faults respond with misaligned and leave memory untouched
        req(1'b0, 2'b10, 1'b0, 'h12, 32'h0, 32'h0, 1'b1, "lw12-fault");
        req(1'b0, 2'b01, 1'b0, 'h11, 32'h0, 32'h0, 1'b1, "lh11-fault");
        req(1'b0, 2'b11, 1'b0, 'h20, 32'h0, 32'h0, 1'b1, "size3-fault");
        req(1'b1, 2'b10, 1'b0, 'h12, 32'h0BADF00D, 32'h0, 1'b1, "sw12-fault");
        ld(2'b10, 1'b0, 'h10, 32'h88997F34, "lw10-unchanged");
        ld(2'b10, 1'b0, 'h20, 32'h0, "lw20-zero");

        // 5: protected region drops stores; first unprotected byte is writable
        st(2'b10, 'h0, 32'hDEADBEEF, "sw0-prot");
        st(2'b00, 'h3, 32'h00000055, "sb3-prot");
        ld(2'b10, 1'b0, 'h0, 32'h0, "lw0");
        ld(2'b00, 1'b0, 'h3, 32'h0, "lb3");
        st(2'b10, 'h4, 32'h01020304, "sw4");
        ld(2'b10, 1'b0, 'h4, 32'h01020304, "lw4");
        drain();
        dbg_addr = 7'h12;
        @(negedge clk);
        check_lit(dbg_data, 32'h88997F34, "dbg12");
        dbg_addr = 7'h06;
        @(negedge clk);
        check_lit(dbg_data, 32'h01020304, "dbg06");
        dbg_addr = 7'h02;
        @(negedge clk);
        check_lit(dbg_data, 32'h0, "dbg02");

        // 6: pipelined stream, reset with responses in flight, clear restarts
        dbg_addr = 7'h40;
        st(2'b10, 'h40, 32'h11223344, "sw40");
        ld(2'b10, 1'b0, 'h40, 32'h11223344, "lw40-a");
        ld(2'b10, 1'b0, 'h40, 32'h11223344, "lw40-b");
        ld(2'b01, 1'b0, 'h10, 32'h00007F34, "lh10");
        reset_count(1'b1, "clear-len-2");
        ld(2'b10, 1'b0, 'h40, 32'h0, "lw40-cleared");
        ld(2'b10, 1'b0, 'h08, 32'h0, "lw08-ignored");
        ld(2'b10, 1'b0, 'h10, 32'h0, "lw10-cleared");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
